// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the two mux sources and the select arbiter.
// The requesters use the master modport. The arbiter uses the slave modport.
interface mux_sel_arbiter_if;
    logic req_a;
    logic req_b;
    logic sel;
    logic gnt_a;
    logic gnt_b;
    logic out_valid;

    modport master (
        output req_a,
        output req_b,
        input  sel,
        input  gnt_a,
        input  gnt_b,
        input  out_valid
    );

    modport slave (
        input  req_a,
        input  req_b,
        output sel,
        output gnt_a,
        output gnt_b,
        output out_valid
    );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin, burst-bounded arbiter that drives the select of a 2:1 mux (sel=0 routes A).
// Define ARB_STATS_EN to add the per-source grant-cycle counters gnt_cnt_a/gnt_cnt_b.
module mux_sel_arbiter #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    mux_sel_arbiter_if.slave   bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]        gnt_cnt_a,
    output logic [15:0]        gnt_cnt_b
`endif
);

    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_b_q, last_b_d;
    logic             sel_q, sel_d;
    logic             enter_a, enter_b;

    always_comb begin
        // NOTE: every signal gets a default before the case statement. A path that leaves one unassigned would infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_b_d = last_b_q;
        sel_d    = sel_q;
        enter_a  = 1'b0;
        enter_b  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req_a && (!bus.req_b || last_b_q)) enter_a = 1'b1;
                else if (bus.req_b)                        enter_b = 1'b1;
            end
            GNT_A: begin
                if (!bus.req_a) begin
                    if (bus.req_b) enter_b = 1'b1;
                    else           state_d = IDLE;
                end else if (bus.req_b && cnt_q == CNT_MAX) begin
                    enter_b = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GNT_B: begin
                if (!bus.req_b) begin
                    if (bus.req_a) enter_a = 1'b1;
                    else           state_d = IDLE;
                end else if (bus.req_a && cnt_q == CNT_MAX) begin
                    enter_a = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Entering a grant restarts the burst and records the owner for the next tie-break.
        if (enter_a) begin
            state_d  = GNT_A;
            cnt_d    = '0;
            sel_d    = 1'b0;
            last_b_d = 1'b0;
        end else if (enter_b) begin
            state_d  = GNT_B;
            cnt_d    = '0;
            sel_d    = 1'b1;
            last_b_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every register samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_b_q <= 1'b1;
            sel_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_b_q <= last_b_d;
            sel_q    <= sel_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.gnt_a     = (state_q == GNT_A);
    assign bus.gnt_b     = (state_q == GNT_B);
    assign bus.out_valid = (state_q != IDLE);

`ifdef ARB_STATS_EN
    logic [15:0] gnt_cnt_a_q, gnt_cnt_b_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt_a_q <= '0;
            gnt_cnt_b_q <= '0;
        end else begin
            gnt_cnt_a_q <= gnt_cnt_a_q + {15'd0, state_q == GNT_A};
            gnt_cnt_b_q <= gnt_cnt_b_q + {15'd0, state_q == GNT_B};
        end
    end

    assign gnt_cnt_a = gnt_cnt_a_q;
    assign gnt_cnt_b = gnt_cnt_b_q;
`endif

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Scoreboarded bench for mux_sel_arbiter: a reference model pushes the expected outputs each cycle.
// The bench pops and compares those outputs after the clock edge, and adds directed checks for the reset, burst and handover cases.
module tb_mux_sel_arbiter;

    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic rst;

    mux_sel_arbiter_if bus ();

`ifdef ARB_STATS_EN
    logic [15:0] gnt_cnt_a, gnt_cnt_b;
    logic [15:0] snap_a, snap_b;
`endif

    mux_sel_arbiter #(.MAX_BURST(MAX_BURST), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef ARB_STATS_EN
        ,
        .gnt_cnt_a (gnt_cnt_a),
        .gnt_cnt_b (gnt_cnt_b)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic        ga;
        logic        gb;
        logic        ov;
        logic [15:0] ca;
        logic [15:0] cb;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // The reference model tracks the owner and the number of cycles served in the current grant.
    int          m_owner;
    int          m_run;
    logic        m_last_b;
    logic        m_sel;
    logic [15:0] m_ca;
    logic [15:0] m_cb;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic grant(input int who);
        m_owner  = who;
        m_run    = 1;
        m_sel    = (who == 2);
        m_last_b = (who == 2);
    endtask

    task automatic model_step(input logic ra, input logic rb, input logic r);
        exp_t e;
        if (r) begin
            m_owner  = 0;
            m_run    = 0;
            m_last_b = 1'b1;
            m_sel    = 1'b0;
            m_ca     = '0;
            m_cb     = '0;
        end else begin
            m_ca = m_ca + ((m_owner == 1) ? 16'd1 : 16'd0);
            m_cb = m_cb + ((m_owner == 2) ? 16'd1 : 16'd0);
            case (m_owner)
                1: begin
                    if (ra && !(rb && m_run >= MAX_BURST)) m_run = (m_run < MAX_BURST) ? m_run + 1 : m_run;
                    else if (rb) grant(2);
                    else m_owner = 0;
                end
                2: begin
                    if (rb && !(ra && m_run >= MAX_BURST)) m_run = (m_run < MAX_BURST) ? m_run + 1 : m_run;
                    else if (ra) grant(1);
                    else m_owner = 0;
                end
                default: begin
                    if (ra && rb) grant(m_last_b ? 1 : 2);
                    else if (ra) grant(1);
                    else if (rb) grant(2);
                end
            endcase
        end
        e.sel = m_sel;
        e.ga  = (m_owner == 1);
        e.gb  = (m_owner == 2);
        e.ov  = (m_owner != 0);
        e.ca  = m_ca;
        e.cb  = m_cb;
        sb_q.push_back(e);
    endtask

    // Drive one cycle of stimulus, predict the result, then compare it 1 time unit after the edge.
    task automatic cycle(input logic ra, input logic rb, input logic r, input string tag);
        exp_t e;
        bus.req_a = ra;
        bus.req_b = rb;
        rst       = r;
        model_step(ra, rb, r);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({tag, ".sel"},       {15'd0, bus.sel},       {15'd0, e.sel});
        check({tag, ".gnt_a"},     {15'd0, bus.gnt_a},     {15'd0, e.ga});
        check({tag, ".gnt_b"},     {15'd0, bus.gnt_b},     {15'd0, e.gb});
        check({tag, ".out_valid"}, {15'd0, bus.out_valid}, {15'd0, e.ov});
        check({tag, ".onehot"},    {15'd0, bus.gnt_a & bus.gnt_b}, 16'd0);
`ifdef ARB_STATS_EN
        check({tag, ".cnt_a"}, gnt_cnt_a, e.ca);
        check({tag, ".cnt_b"}, gnt_cnt_b, e.cb);
`endif
    endtask

    initial begin
        logic [15:0] pat_a;
        pat_a     = 16'b1111_0000_1111_0000;
        rst       = 1'b1;
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;

        // Reset held with both requesting, then A wins the first tie.
        cycle(1'b1, 1'b1, 1'b1, "rst0");
        cycle(1'b1, 1'b1, 1'b1, "rst1");
        check("rst.gnt_a", {15'd0, bus.gnt_a}, 16'd0);
        check("rst.out_valid", {15'd0, bus.out_valid}, 16'd0);
        check("rst.sel", {15'd0, bus.sel}, 16'd0);
        cycle(1'b1, 1'b1, 1'b0, "rel");
        check("rel.gnt_a", {15'd0, bus.gnt_a}, 16'd1);
        check("rel.sel", {15'd0, bus.sel}, 16'd0);
        cycle(1'b0, 1'b0, 1'b0, "idle0");

        // A single source holds the path beyond MAX_BURST cycles.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 1'b0, "solo_b");
            check("solo_b.gnt_b", {15'd0, bus.gnt_b}, 16'd1);
            check("solo_b.sel", {15'd0, bus.sel}, 16'd1);
        end
        cycle(1'b0, 1'b0, 1'b0, "idle1");
        check("idle1.out_valid", {15'd0, bus.out_valid}, 16'd0);
        check("idle1.sel_hold", {15'd0, bus.sel}, 16'd1);

        // Fairness: both requesting gives the grant pattern AAAABBBBAAAABBBB.
`ifdef ARB_STATS_EN
        snap_a = gnt_cnt_a;
        snap_b = gnt_cnt_b;
`endif
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b1, 1'b0, "fair");
            check("fair.pat_a", {15'd0, bus.gnt_a}, {15'd0, pat_a[15-i]});
            check("fair.pat_sel", {15'd0, bus.sel}, {15'd0, ~pat_a[15-i]});
            check("fair.valid", {15'd0, bus.out_valid}, 16'd1);
        end
        cycle(1'b0, 1'b0, 1'b0, "idle2");
`ifdef ARB_STATS_EN
        check("fair.delta_a", gnt_cnt_a - snap_a, 16'd8);
        check("fair.delta_b", gnt_cnt_b - snap_b, 16'd8);
`endif

        // Early release: A drops at burst_cnt=1 and B takes over with no idle cycle.
        cycle(1'b1, 1'b0, 1'b0, "early0");
        cycle(1'b1, 1'b0, 1'b0, "early1");
        cycle(1'b0, 1'b1, 1'b0, "early2");
        check("early.gnt_b", {15'd0, bus.gnt_b}, 16'd1);
        check("early.sel", {15'd0, bus.sel}, 16'd1);
        check("early.valid", {15'd0, bus.out_valid}, 16'd1);

        // Reset mid-burst in GNT_B at burst_cnt=2.
        cycle(1'b0, 1'b1, 1'b0, "midb0");
        cycle(1'b0, 1'b1, 1'b0, "midb1");
        cycle(1'b1, 1'b1, 1'b1, "midrst");
        check("midrst.gnt_b", {15'd0, bus.gnt_b}, 16'd0);
        check("midrst.sel", {15'd0, bus.sel}, 16'd0);
        check("midrst.valid", {15'd0, bus.out_valid}, 16'd0);
        cycle(1'b1, 1'b1, 1'b0, "after");
        check("after.gnt_a", {15'd0, bus.gnt_a}, 16'd1);

        // Random traffic with occasional resets, checked only against the model.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 39) == 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
